// File: rtl/debug_autobaud_tx.sv
// Debug UART transmitter: 8N1/8N2 frames at div*32 clks per bit, with 0x55 training bursts for far-end auto-baud lock.
// Define DEBUG_AUTOBAUD_TX_PARITY_EN to insert an even parity bit after the data bits.
module debug_autobaud_tx #(
  parameter int SYNC_COUNT = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       div_wr,
  input  logic [7:0] div_in,
  input  logic       sync_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       sync_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef DEBUG_AUTOBAUD_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [3:0] SYNC_LD   = 4'(SYNC_COUNT);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  pdiv_q, pdiv_d;
  logic        pend_q, pend_d;
  logic [3:0]  scnt_q, scnt_d;
  logic        last_q, last_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic        sidx_q, sidx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        start_sync, start_data, frame_end, bit_end;
  logic [12:0] bit_ld;

  assign bit_ld     = {div_q, 5'b0} - 13'd1;
  assign bit_end    = (cnt_q == 13'd0);
  assign start_sync = (state_q == S_IDLE) && (scnt_q != 4'd0) && (div_q != 8'd0);
  // rdy_q is never set while training is pending, so training always wins
  assign start_data = (state_q == S_IDLE) && tx_valid && tx_ready;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pdiv_d    = pdiv_q;
    pend_d    = pend_q;
    scnt_d    = scnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    sidx_d    = sidx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_sync || start_data) begin
          state_d = S_START;
          tx_d    = 1'b0;
          cnt_d   = bit_ld;
          shift_d = start_sync ? 8'h55 : tx_data;
          last_d  = start_sync && (scnt_q == 4'd1);
          if (start_sync) scnt_d = scnt_q - 4'd1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bidx_d  = 3'd0;
          tx_d    = shift_q[0];
          cnt_d   = bit_ld;
        end else cnt_d = cnt_q - 13'd1;
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = bit_ld;
          if (bidx_q == 3'd7) begin
`ifdef DEBUG_AUTOBAUD_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
            sidx_d  = 1'b0;
`endif
          end else begin
            bidx_d = bidx_q + 3'd1;
            tx_d   = shift_q[bidx_q + 3'd1];
          end
        end else cnt_d = cnt_q - 13'd1;
      end
`ifdef DEBUG_AUTOBAUD_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          sidx_d  = 1'b0;
          cnt_d   = bit_ld;
        end else cnt_d = cnt_q - 13'd1;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (sidx_q == STOP_LAST) begin
            state_d   = S_IDLE;
            frame_end = 1'b1;
            done_d    = last_q;
            last_d    = 1'b0;
          end else begin
            sidx_d = 1'b1;
            cnt_d  = bit_ld;
          end
        end else cnt_d = cnt_q - 13'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (sync_req) begin
      scnt_d = SYNC_LD;
      last_d = 1'b0;
    end

    // Divisor only changes between frames; a write landing on the last stop edge is the newest value
    if (frame_end) begin
      div_d  = div_wr ? div_in : (pend_q ? pdiv_q : div_q);
      pend_d = 1'b0;
    end else if ((state_q == S_IDLE) && !(start_sync || start_data)) begin
      if (div_wr) begin
        div_d  = div_in;
        pend_d = 1'b0;
      end
    end else if (div_wr) begin
      pdiv_d = div_in;
      pend_d = 1'b1;
    end

    rdy_d = (state_d == S_IDLE) && (div_d != 8'd0) && (scnt_d == 4'd0) && !pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      pdiv_q  <= 8'd0;
      pend_q  <= 1'b0;
      scnt_q  <= 4'd0;
      last_q  <= 1'b0;
      cnt_q   <= 13'd0;
      bidx_q  <= 3'd0;
      sidx_q  <= 1'b0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      scnt_q  <= scnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sidx_q  <= sidx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready  = rdy_q & ~sync_req;
  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE) || (scnt_q != 4'd0);
  assign sync_done = done_q;

endmodule

// File: tb/tb_debug_autobaud_tx.sv
// Randomized bench for debug_autobaud_tx: expected line waveform is built from the frame format rules.
module tb_debug_autobaud_tx;

  localparam int SYNC_N = 4;
  localparam int STOPB  = 1;
`ifdef DEBUG_AUTOBAUD_TX_PARITY_EN
  localparam int NBITS = 11 + STOPB - 1;
`else
  localparam int NBITS = 10 + STOPB - 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_wr = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       sync_req = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, sync_done;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  debug_autobaud_tx #(.SYNC_COUNT(SYNC_N), .STOP_BITS(STOPB)) dut (
    .clk(clk), .rst_n(rst_n), .div_wr(div_wr), .div_in(div_in), .sync_req(sync_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .busy(busy),
    .sync_done(sync_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line level for bit slot k of a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef DEBUG_AUTOBAUD_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic set_div(input logic [7:0] d);
    @(posedge clk); #1;
    div_wr = 1'b1; div_in = d;
    @(posedge clk); #1;
    div_wr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic s);
    logic acc;
    acc = 1'b0;
    @(posedge clk); #1;
    tx_data = b; tx_valid = 1'b1; sync_req = s;
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      acc = tx_ready;
      @(posedge clk); #1;
      sync_req = 1'b0;
      if (acc) break;
    end
    tx_valid = 1'b0;
    sync_req = 1'b0;
    chk("accepted", 32'(acc), 32'(1));
  endtask

  task automatic recv(input logic [7:0] b, input int p, input logic exp_done);
    logic       seen;
    logic [7:0] got;
    int         errs;
    seen = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("start_seen", 32'(seen), 32'(1));
    if (!seen) return;
    chk("busy_in_frame", 32'(busy), 32'(1));
    errs = 0;
    got  = 8'd0;
    for (int c = 0; c < NBITS * p; c++) begin
      if (c > 0) @(negedge clk);
      if (tx !== frame_bit(b, c / p)) errs++;
      if ((c % p == p / 2) && (c / p >= 1) && (c / p <= 8)) got[c/p-1] = tx;
    end
    chk("frame_cycles_wrong", 32'(errs), 32'(0));
    chk("rx_byte", 32'(got), 32'(b));
    @(negedge clk);
    chk("idle_after_stop", 32'(tx), 32'(1));
    chk("sync_done", 32'(sync_done), 32'(exp_done));
  endtask

  task automatic xfer(input logic [7:0] b, input logic s, input int p);
    fork
      send(b, s);
      begin
        if (s) for (int i = 0; i < SYNC_N; i++) recv(8'h55, p, i == SYNC_N - 1);
        recv(b, p, 1'b0);
      end
    join
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic saw_rdy, saw_low;
    logic [7:0] rb;
    int rd;
    logic rs;

    #23;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_ready", 32'(tx_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sync_done", 32'(sync_done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // No divisor yet: the line must stay idle and nothing is accepted
    tx_data = 8'h3C; tx_valid = 1'b1;
    saw_rdy = 1'b0; saw_low = 1'b0;
    repeat (10000) begin
      @(negedge clk);
      if (tx_ready) saw_rdy = 1'b1;
      if (!tx) saw_low = 1'b1;
    end
    chk("div0_ready", 32'(saw_rdy), 32'(0));
    chk("div0_tx", 32'(saw_low), 32'(0));
    chk("div0_busy", 32'(busy), 32'(0));
    tx_valid = 1'b0;
    set_div(8'd2);
    xfer(8'h3C, 1'b0, 64);

    set_div(8'd1);
    xfer(8'hA5, 1'b0, 32);
    chk("ready_after_stop", 32'(tx_ready), 32'(1));

    set_div(8'd2);
    xfer(8'h41, 1'b1, 64);

    // Divisor written mid-frame only applies to the following frame
    set_div(8'd1);
    fork
      xfer(8'h5A, 1'b0, 32);
      begin
        repeat (100) @(posedge clk);
        #1 div_wr = 1'b1; div_in = 8'd3;
        @(posedge clk); #1 div_wr = 1'b0;
      end
    join
    xfer(8'hC3, 1'b0, 96);

    set_div(8'd1);
    send(8'h00, 1'b0);
    repeat (140) @(posedge clk);
    #2;
    chk("pre_rst_tx", 32'(tx), 32'(0));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    #20 rst_n = 1'b1;
    tx_data = 8'h99; tx_valid = 1'b1;
    saw_rdy = 1'b0; saw_low = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (tx_ready) saw_rdy = 1'b1;
      if (!tx) saw_low = 1'b1;
    end
    chk("postrst_ready", 32'(saw_rdy), 32'(0));
    chk("postrst_tx", 32'(saw_low), 32'(0));
    tx_valid = 1'b0;

    for (int it = 0; it < 12; it++) begin
      rd = $urandom_range(1, 3);
      rb = 8'($urandom);
      rs = ($urandom % 4) == 0;
      set_div(8'(rd));
      xfer(rb, rs, rd * 32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
